// File: rtl/observe_point_gen.sv
// observe_point_gen: follows the raster position of the active-video stream and,
// one cycle after each accepted pixel, presents the centre of the tile holding that
// pixel together with the gaze point latched at the start of the frame.
module observe_point_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int TILE_W   = 12,
    parameter int TILE_H   = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_valid,
    input  logic        i_sof,
    input  logic        i_eol,
    input  logic        i_gaze_valid,
    input  logic [10:0] i_gaze_x,
    input  logic [10:0] i_gaze_y,
    output logic        o_data_valid,
    output logic [10:0] o_gaze_x,
    output logic [10:0] o_gaze_y,
    output logic [10:0] o_observe_x,
    output logic [10:0] o_observe_y,
    output logic        o_frame_done,
    output logic        o_frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] COL_LAST = 11'(TILE_W - 1);
    localparam logic [10:0] ROW_LAST = 11'(TILE_H - 1);
    localparam logic [11:0] CX_INIT  = 12'(TILE_W / 2);
    localparam logic [11:0] CY_INIT  = 12'(TILE_H / 2);
    localparam logic [11:0] CX_STEP  = 12'(TILE_W);
    localparam logic [11:0] CY_STEP  = 12'(TILE_H);

    state_t      state_q;

    // Position of the next expected pixel, its place inside the tile and the
    // unclamped centre of that tile (one bit wider so the last partial tile
    // cannot wrap before clamping).
    logic [10:0] xCount_q, xCount_d;
    logic [10:0] yCount_q, yCount_d;
    logic [10:0] tileCol_q, tileCol_d;
    logic [10:0] tileRow_q, tileRow_d;
    logic [11:0] centreX_q, centreX_d;
    logic [11:0] centreY_q, centreY_d;

    logic [10:0] pendGazeX_q, pendGazeY_q;

    logic        dataValid_q;
    logic [10:0] gazeX_q, gazeY_q;
    logic [10:0] observeX_q, observeY_q;
    logic        frameDone_q;
    logic        frameErr_q;

    logic        accept;
    logic [10:0] pixX, pixY, pixCol, pixRow;
    logic [11:0] pixCentreX, pixCentreY;
    logic        atLineEnd, lastLine;
    logic [10:0] obsX_d, obsY_d;
    logic        frameDone_d;
    logic        errSet;

    // Resolve where the current pixel sits (a start-of-frame pixel is always at the
    // origin), decide its clamped tile centre and work out the counters for the next one.
    always_comb begin
        accept     = i_pix_valid && (i_sof || (state_q == ACTIVE));

        pixX       = i_sof ? 11'd0   : xCount_q;
        pixY       = i_sof ? 11'd0   : yCount_q;
        pixCol     = i_sof ? 11'd0   : tileCol_q;
        pixRow     = i_sof ? 11'd0   : tileRow_q;
        pixCentreX = i_sof ? CX_INIT : centreX_q;
        pixCentreY = i_sof ? CY_INIT : centreY_q;

        atLineEnd  = (pixX == X_LAST);
        lastLine   = (pixY == Y_LAST);

        obsX_d = (pixCentreX > {1'b0, X_LAST}) ? X_LAST : pixCentreX[10:0];
        obsY_d = (pixCentreY > {1'b0, Y_LAST}) ? Y_LAST : pixCentreY[10:0];

        xCount_d  = xCount_q;
        yCount_d  = yCount_q;
        tileCol_d = tileCol_q;
        tileRow_d = tileRow_q;
        centreX_d = centreX_q;
        centreY_d = centreY_q;

        if (accept) begin
            xCount_d  = pixX;
            yCount_d  = pixY;
            tileCol_d = pixCol;
            tileRow_d = pixRow;
            centreX_d = pixCentreX;
            centreY_d = pixCentreY;

            if (i_eol) begin
                xCount_d  = 11'd0;
                tileCol_d = 11'd0;
                centreX_d = CX_INIT;
                if (!lastLine) begin
                    yCount_d = pixY + 11'd1;
                    if (pixRow == ROW_LAST) begin
                        tileRow_d = 11'd0;
                        centreY_d = pixCentreY + CY_STEP;
                    end else begin
                        tileRow_d = pixRow + 11'd1;
                    end
                end
            end else if (!atLineEnd) begin
                xCount_d = pixX + 11'd1;
                if (pixCol == COL_LAST) begin
                    tileCol_d = 11'd0;
                    centreX_d = pixCentreX + CX_STEP;
                end else begin
                    tileCol_d = pixCol + 11'd1;
                end
            end
        end

        frameDone_d = accept && i_eol && lastLine;

        errSet = (accept && i_eol && !atLineEnd)
              || (accept && !i_eol && atLineEnd)
              || (i_pix_valid && i_sof && (state_q == ACTIVE))
              || (i_pix_valid && !i_sof && (state_q == DONE));
    end

    // Frame state, raster counters, pending gaze and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            xCount_q    <= '0;
            yCount_q    <= '0;
            tileCol_q   <= '0;
            tileRow_q   <= '0;
            centreX_q   <= '0;
            centreY_q   <= '0;
            pendGazeX_q <= '0;
            pendGazeY_q <= '0;
            dataValid_q <= 1'b0;
            gazeX_q     <= '0;
            gazeY_q     <= '0;
            observeX_q  <= '0;
            observeY_q  <= '0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            xCount_q  <= xCount_d;
            yCount_q  <= yCount_d;
            tileCol_q <= tileCol_d;
            tileRow_q <= tileRow_d;
            centreX_q <= centreX_d;
            centreY_q <= centreY_d;

            if (i_gaze_valid) begin
                pendGazeX_q <= i_gaze_x;
                pendGazeY_q <= i_gaze_y;
            end

            dataValid_q <= accept;
            frameDone_q <= frameDone_d;

            if (accept) begin
                observeX_q <= obsX_d;
                observeY_q <= obsY_d;
                state_q    <= frameDone_d ? DONE : ACTIVE;
                if (i_sof) begin
                    gazeX_q <= i_gaze_valid ? i_gaze_x : pendGazeX_q;
                    gazeY_q <= i_gaze_valid ? i_gaze_y : pendGazeY_q;
                end
            end

            if (errSet) begin
                frameErr_q <= 1'b1;
            end else if (accept && i_sof) begin
                frameErr_q <= 1'b0;
            end
        end
    end

    assign o_data_valid = dataValid_q;
    assign o_gaze_x     = gazeX_q;
    assign o_gaze_y     = gazeY_q;
    assign o_observe_x  = observeX_q;
    assign o_observe_y  = observeY_q;
    assign o_frame_done = frameDone_q;
    assign o_frame_err  = frameErr_q;

endmodule
